// File: rtl/seven_segments_reader_if.sv
// Handshake bundle for seven_segments_reader: segment image in, decoded value out.
// slave  : the reader itself
// master : whoever drives segment images and consumes results
interface seven_segments_reader_if #(
    parameter int unsigned NDIGITS = 3,
    parameter int unsigned VAL_W   = 10
) ();

    logic [7*NDIGITS-1:0] segs;
    logic                 in_valid;
    logic                 in_ready;
    logic [VAL_W-1:0]     value;
    logic                 err;
    logic [NDIGITS-1:0]   err_mask;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  segs,
        input  in_valid,
        output in_ready,
        output value,
        output err,
        output err_mask,
        output out_valid,
        input  out_ready
    );

    modport master (
        output segs,
        output in_valid,
        input  in_ready,
        input  value,
        input  err,
        input  err_mask,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/seven_segments_reader.sv
// Reads a packed active-low multi-digit 7-segment image and rebuilds its decimal value,
// one digit per cycle, most significant digit first.
// Optional feature: define SEG_READER_BLANK_EN to accept the all-off pattern as a legal
// blank digit (decodes as 0, no error flag).
module seven_segments_reader #(
    parameter int unsigned NDIGITS        = 3,
    parameter int unsigned VAL_W          = 10,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    seven_segments_reader_if.slave bus
);

    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StDec, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [7*NDIGITS-1:0] r_segs;
    logic [VAL_W-1:0]     r_acc;
    logic [IDX_W-1:0]     r_idx;
    logic [NDIGITS-1:0]   r_mask;
    logic [VAL_W-1:0]     r_value;
    logic                 r_err;
    logic [NDIGITS-1:0]   r_err_mask;
    logic                 r_out_valid;

    logic [7*NDIGITS-1:0] w_segs_cap;
    logic [6:0]           w_digits [NDIGITS];
    logic [6:0]           w_seg_digit;
    logic [3:0]           w_digit;
    logic                 w_illegal;
    logic [VAL_W-1:0]     w_acc_next;
    logic [NDIGITS-1:0]   w_mask_next;

    // Normalise capture to active-low so the decode table is polarity independent
    assign w_segs_cap = SEG_ACTIVE_LOW ? bus.segs : ~bus.segs;

    // Split the captured image into per-digit fields and pick the one being decoded
    always_comb begin
        for (int k = 0; k < int'(NDIGITS); k++) begin
            w_digits[k] = r_segs[7*k +: 7];
        end
        w_seg_digit = w_digits[r_idx];
    end

    // Active-low {g,f,e,d,c,b,a} pattern to digit; illegal patterns decode as 0
    always_comb begin
        w_digit   = 4'd0;
        w_illegal = 1'b0;
        case (w_seg_digit)
            7'b1000000: w_digit = 4'd0;
            7'b1111001: w_digit = 4'd1;
            7'b0100100: w_digit = 4'd2;
            7'b0110000: w_digit = 4'd3;
            7'b0011001: w_digit = 4'd4;
            7'b0010010: w_digit = 4'd5;
            7'b0000010: w_digit = 4'd6;
            7'b1111000: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0011000: w_digit = 4'd9;
`ifdef SEG_READER_BLANK_EN
            7'b1111111: w_digit = 4'd0;
`endif
            default:    w_illegal = 1'b1;
        endcase
    end

    // Horner step: result never exceeds 10**NDIGITS-1, so VAL_W bits cannot overflow
    always_comb begin
        w_acc_next  = VAL_W'(r_acc * VAL_W'(10)) + VAL_W'(w_digit);
        w_mask_next = r_mask;
        if (w_illegal) begin
            w_mask_next = r_mask | (NDIGITS'(1) << r_idx);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.in_valid)   w_state_next = StDec;
            StDec:   if (r_idx == '0)    w_state_next = StDone;
            StDone:  if (bus.out_ready)  w_state_next = StIdle;
            default:                     w_state_next = StIdle;
        endcase
    end

    // FSM outputs; result fields come straight from their holding registers
    always_comb begin
        bus.in_ready  = (r_state == StIdle);
        bus.out_valid = r_out_valid;
        bus.value     = r_value;
        bus.err       = r_err;
        bus.err_mask  = r_err_mask;
    end

    // Datapath: capture, per-digit accumulate, result load and release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_segs      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_err       <= 1'b0;
            r_err_mask  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_segs <= w_segs_cap;
                        r_acc  <= '0;
                        r_idx  <= IDX_W'(NDIGITS - 1);
                        r_mask <= '0;
                    end
                end
                StDec: begin
                    r_acc  <= w_acc_next;
                    r_mask <= w_mask_next;
                    r_idx  <= r_idx - 1'b1;
                    if (r_idx == '0) begin
                        r_value     <= w_acc_next;
                        r_err_mask  <= w_mask_next;
                        r_err       <= |w_mask_next;
                        r_out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    // value/err/err_mask intentionally keep their last result
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule
